// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-Lite pipeline.
//   - DEFAULT_* : default geometry of the register file / scoreboard
//   - reg_idx_t, reg_data_t : register index and register value types
//   - opcode_e : primary opcode field values decoded by the pipeline
// Optional feature macro used by consumers of this package:
//   REGFILE_SCOREBOARD_BYPASS_EN (writeback-to-decode operand bypass)
package mips_pkg;

  localparam int DEFAULT_REGISTER_WIDTH = 32;
  localparam int DEFAULT_NUM_REGS       = 32;
  localparam int DEFAULT_PIPE_SIZE      = 5;
  localparam int DEFAULT_ADDR_W         = $clog2(DEFAULT_NUM_REGS);

  typedef logic [DEFAULT_ADDR_W-1:0]                reg_idx_t;
  typedef logic signed [DEFAULT_REGISTER_WIDTH-1:0] reg_data_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

endpackage

// File: rtl/scoreboard_cnt.sv
// scoreboard_cnt: pending-write counter for one architectural register.
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc         : an accepted instruction will write this register
//   dec         : writeback to this register this cycle
//   flush       : squash all in-flight writes (counter to 0)
//   cnt         : number of in-flight writes, 0..PIPE_SIZE
//   underflow   : writeback arrived while cnt == 0 (combinational pulse)
module scoreboard_cnt
  import mips_pkg::*;
#(
  parameter  int PIPE_SIZE = DEFAULT_PIPE_SIZE,
  localparam int CNT_W     = $clog2(PIPE_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIPE_SIZE);

  logic dec_ok;

  // A writeback with nothing pending is reported but never wraps the counter.
  assign dec_ok    = dec && (cnt != '0);
  assign underflow = dec && (cnt == '0);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      // Flush wins over a same-cycle issue: the squashed issue is not counted.
      cnt <= '0;
    end else if (inc && !dec_ok && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end else if (dec_ok && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with RAW/WAW hazard scoreboard for the
// MIPS-Lite 5-stage pipeline.
//   CLOCK, RESET_N  : clock (rising edge), asynchronous active-low reset
//   iss_*           : instruction issue from decode (valid, wr, dest, src, src_used)
//   rd_data         : source operands, port p at [p*REGISTER_WIDTH +: REGISTER_WIDTH]
//   stall           : issue blocked this cycle; iss_accept = iss_valid && !stall
//   wb_*            : writeback retirement (valid, dest, signed data)
//   flush           : clear every pending counter at the next edge
//   stall_count     : free-running count of stalled issue cycles (wraps)
//   err_underflow   : sticky, a writeback found its register with nothing pending
// Optional feature macro: REGFILE_SCOREBOARD_BYPASS_EN
//   defined   -> writeback data is forwarded to matching read ports, and a RAW
//                hazard whose last pending write retires this cycle is released
//   undefined -> operands come from committed registers only
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter  int REGISTER_WIDTH = DEFAULT_REGISTER_WIDTH,
  parameter  int NUM_REGS       = DEFAULT_NUM_REGS,
  parameter  int NUM_RD_PORTS   = 2,
  parameter  int PIPE_SIZE      = DEFAULT_PIPE_SIZE,
  localparam int ADDR_W         = $clog2(NUM_REGS),
  localparam int CNT_W          = $clog2(PIPE_SIZE + 1)
) (
  input  logic                                   CLOCK,
  input  logic                                   RESET_N,
  input  logic                                   iss_valid,
  input  logic                                   iss_wr,
  input  logic [ADDR_W-1:0]                      iss_dest,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0]         iss_src,
  input  logic [NUM_RD_PORTS-1:0]                iss_src_used,
  output logic [NUM_RD_PORTS*REGISTER_WIDTH-1:0] rd_data,
  output logic                                   stall,
  output logic                                   iss_accept,
  input  logic                                   wb_valid,
  input  logic [ADDR_W-1:0]                      wb_dest,
  input  logic signed [REGISTER_WIDTH-1:0]       wb_data,
  input  logic                                   flush,
  output logic [31:0]                            stall_count,
  output logic                                   err_underflow
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(PIPE_SIZE);

  logic signed [REGISTER_WIDTH-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]                 pend [NUM_REGS];
  logic [NUM_REGS-1:0]              inc_vec;
  logic [NUM_REGS-1:0]              dec_vec;
  logic [NUM_REGS-1:0]              uf_vec;
  logic                             raw_any;
  logic                             struct_hz;

  // ---------------------------------------------------------------------------
  // Pending-write counters, one per writable register; R0 never pends.
  // ---------------------------------------------------------------------------
  assign pend[0]    = '0;
  assign inc_vec[0] = 1'b0;
  assign dec_vec[0] = 1'b0;
  assign uf_vec[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    assign inc_vec[r] = iss_accept && iss_wr && (iss_dest == ADDR_W'(r));
    assign dec_vec[r] = wb_valid && (wb_dest == ADDR_W'(r));

    scoreboard_cnt #(
      .PIPE_SIZE (PIPE_SIZE)
    ) u_cnt (
      .clk       (CLOCK),
      .rst_n     (RESET_N),
      .inc       (inc_vec[r]),
      .dec       (dec_vec[r]),
      .flush     (flush),
      .cnt       (pend[r]),
      .underflow (uf_vec[r])
    );
  end

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // NOTE: this array is reset element by element because its reset contents are
  // architecturally visible; storage with no defined reset value would not be.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_valid && (wb_dest != '0)) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand read and RAW hazard detection
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default at the top of the block,
  // so no path can leave one unassigned and infer a latch.
  always_comb begin
    logic [ADDR_W-1:0]                src;
    logic signed [REGISTER_WIDTH-1:0] operand;
    logic                             hz;
    rd_data = '0;
    raw_any = 1'b0;
    src     = '0;
    operand = '0;
    hz      = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      src     = iss_src[p*ADDR_W +: ADDR_W];
      operand = (src == '0) ? '0 : regs[src];
      hz      = iss_src_used[p] && (src != '0) && (pend[src] != '0);
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
      if (wb_valid && (wb_dest == src) && (src != '0)) begin
        operand = wb_data;
        // The retiring write is the last one outstanding: the forwarded value
        // is final, so the dependent may issue this cycle.
        if (pend[src] == CNT_W'(1)) hz = 1'b0;
      end
`endif
      rd_data[p*REGISTER_WIDTH +: REGISTER_WIDTH] = operand;
      raw_any = raw_any || hz;
    end
  end

  // WAW never stalls; only a saturated pending counter blocks a new writer.
  assign struct_hz  = iss_wr && (iss_dest != '0) && (pend[iss_dest] == PEND_MAX);
  assign stall      = iss_valid && (raw_any || struct_hz);
  assign iss_accept = iss_valid && !stall;

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_count   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (stall) stall_count <= stall_count + 32'd1;
      if (|uf_vec) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed self-checking bench for regfile_scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are checked 3 units
// after the edge, well before the next one. Expected values are hand-computed.
module tb_regfile_scoreboard;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        iss_valid;
  logic        iss_wr;
  logic [4:0]  iss_dest;
  logic [9:0]  iss_src;
  logic [1:0]  iss_src_used;
  logic [63:0] rd_data;
  logic        stall;
  logic        iss_accept;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic signed [31:0] wb_data;
  logic        flush;
  logic [31:0] stall_count;
  logic        err_underflow;

  int tests    = 0;
  int failures = 0;
  int exp_sc   = 0;

  regfile_scoreboard dut (
    .CLOCK         (CLOCK),
    .RESET_N       (RESET_N),
    .iss_valid     (iss_valid),
    .iss_wr        (iss_wr),
    .iss_dest      (iss_dest),
    .iss_src       (iss_src),
    .iss_src_used  (iss_src_used),
    .rd_data       (rd_data),
    .stall         (stall),
    .iss_accept    (iss_accept),
    .wb_valid      (wb_valid),
    .wb_dest       (wb_dest),
    .wb_data       (wb_data),
    .flush         (flush),
    .stall_count   (stall_count),
    .err_underflow (err_underflow)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    iss_valid    = 1'b0;
    iss_wr       = 1'b0;
    iss_dest     = '0;
    iss_src      = '0;
    iss_src_used = '0;
    wb_valid     = 1'b0;
    wb_dest      = '0;
    wb_data      = '0;
    flush        = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [4:0] dest,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    iss_valid    = 1'b1;
    iss_wr       = wr;
    iss_dest     = dest;
    iss_src      = {s1, s0};
    iss_src_used = used;
  endtask

  task automatic wb(input logic [4:0] dest, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_dest  = dest;
    wb_data  = data;
  endtask

  initial begin
    RESET_N = 1'b0;
    idle();
    tick();
    RESET_N = 1'b1;
    settle();
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_rd0", rd_data[31:0], 32'd0);
    check("reset_stall_count", stall_count, 32'd0);
    check("reset_err", {31'd0, err_underflow}, 32'd0);

    // ---- Plain RAW on R3 ----
    tick(); idle();
    issue(1'b1, 5'd3, 5'd0, 5'd0, 2'b00);
    settle();
    check("raw_producer_accept", {31'd0, iss_accept}, 32'd1);
    tick(); idle();
    issue(1'b0, 5'd0, 5'd3, 5'd0, 2'b01);
    settle();
    check("raw_stall_1", {31'd0, stall}, 32'd1);
    exp_sc++;
    tick();
    wb(5'd3, 32'h0000_00AA);
    settle();
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
    check("raw_bypass_accept", {31'd0, iss_accept}, 32'd1);
    check("raw_bypass_rd0", rd_data[31:0], 32'h0000_00AA);
    tick(); idle();
    settle();
`else
    check("raw_stall_2", {31'd0, stall}, 32'd1);
    exp_sc++;
    tick(); idle();
    issue(1'b0, 5'd0, 5'd3, 5'd3, 2'b11);
    settle();
    check("raw_accept_after_wb", {31'd0, iss_accept}, 32'd1);
    check("raw_rd0", rd_data[31:0], 32'h0000_00AA);
    check("raw_rd1", rd_data[63:32], 32'h0000_00AA);
`endif
    check("raw_stall_count", stall_count, exp_sc);

    // ---- R0 rules ----
    tick(); idle();
    issue(1'b1, 5'd0, 5'd0, 5'd0, 2'b00);
    wb(5'd0, 32'hFFFF_FFFF);
    settle();
    check("r0_dest_accept", {31'd0, iss_accept}, 32'd1);
    tick(); idle();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 2'b11);
    settle();
    check("r0_src_no_stall", {31'd0, stall}, 32'd0);
    check("r0_rd0_zero", rd_data[31:0], 32'd0);
    check("r0_wb_no_underflow", {31'd0, err_underflow}, 32'd0);

    // ---- WAW depth on R7 ----
    for (int i = 0; i < 5; i++) begin
      tick(); idle();
      issue(1'b1, 5'd7, 5'd0, 5'd0, 2'b00);
      settle();
      check("waw_issue_accept", {31'd0, iss_accept}, 32'd1);
    end
    tick(); idle();
    issue(1'b1, 5'd7, 5'd0, 5'd0, 2'b00);
    settle();
    check("waw_structural_stall", {31'd0, stall}, 32'd1);
    exp_sc++;
    tick();
    wb(5'd7, 32'h0000_0077);
    settle();
    check("waw_stall_during_wb", {31'd0, stall}, 32'd1);
    exp_sc++;
    tick();
    wb_valid = 1'b0;
    settle();
    check("waw_sixth_accept", {31'd0, iss_accept}, 32'd1);
    check("waw_stall_count", stall_count, exp_sc);

    // ---- Flush ----
    tick(); idle();
    issue(1'b1, 5'd4, 5'd0, 5'd0, 2'b00);
    settle();
    check("flush_producer_accept", {31'd0, iss_accept}, 32'd1);
    tick(); idle();
    flush = 1'b1;
    issue(1'b1, 5'd9, 5'd0, 5'd0, 2'b00);
    settle();
    check("flush_cycle_issue_accept", {31'd0, iss_accept}, 32'd1);
    tick(); idle();
    issue(1'b0, 5'd0, 5'd4, 5'd9, 2'b11);
    settle();
    check("flush_r4_r9_no_stall", {31'd0, stall}, 32'd0);
    tick(); idle();
    issue(1'b0, 5'd0, 5'd7, 5'd7, 2'b11);
    settle();
    check("flush_r7_no_stall", {31'd0, stall}, 32'd0);
    tick(); idle();
    wb(5'd4, 32'hDEAD_BEEF);
    settle();
    check("flush_err_before_edge", {31'd0, err_underflow}, 32'd0);
    tick(); idle();
    issue(1'b0, 5'd0, 5'd4, 5'd0, 2'b01);
    settle();
    check("flush_err_sticky_set", {31'd0, err_underflow}, 32'd1);
    check("flush_late_wb_data", rd_data[31:0], 32'hDEAD_BEEF);

    // ---- Same-cycle inc/dec on R5 ----
    tick(); idle();
    issue(1'b1, 5'd5, 5'd0, 5'd0, 2'b00);
    tick(); idle();
    issue(1'b1, 5'd5, 5'd0, 5'd0, 2'b00);
    wb(5'd5, 32'h0000_0055);
    settle();
    check("incdec_accept", {31'd0, iss_accept}, 32'd1);
    tick(); idle();
    issue(1'b0, 5'd0, 5'd5, 5'd0, 2'b01);
    settle();
    check("incdec_pend_still_1", {31'd0, stall}, 32'd1);
    check("incdec_reg_updated", rd_data[31:0], 32'h0000_0055);
    exp_sc++;
    tick(); idle();
    issue(1'b0, 5'd0, 5'd5, 5'd0, 2'b00);
    settle();
    check("src_unused_no_stall", {31'd0, stall}, 32'd0);
    tick(); idle();
    wb(5'd5, 32'h0000_0066);
    tick(); idle();
    issue(1'b0, 5'd0, 5'd5, 5'd0, 2'b01);
    settle();
    check("incdec_drained", {31'd0, stall}, 32'd0);
    check("incdec_final_data", rd_data[31:0], 32'h0000_0066);
    check("total_stall_count", stall_count, exp_sc);

    // ---- Reset mid-operation with pend[3]=2 ----
    tick(); idle();
    issue(1'b1, 5'd3, 5'd0, 5'd0, 2'b00);
    tick();
    tick(); idle();
    issue(1'b0, 5'd0, 5'd3, 5'd0, 2'b01);
    settle();
    check("pre_reset_r3_stall", {31'd0, stall}, 32'd1);
    tick();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    issue(1'b0, 5'd0, 5'd3, 5'd5, 2'b11);
    settle();
    check("midreset_stall", {31'd0, stall}, 32'd0);
    check("midreset_rd0", rd_data[31:0], 32'd0);
    check("midreset_rd1", rd_data[63:32], 32'd0);
    check("midreset_stall_count", stall_count, 32'd0);
    check("midreset_err", {31'd0, err_underflow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
